mdu: RTL and testbench
======================

MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5: BUSY duration in cycles for MULT/MULTU.
REQ-002 Parameter DIV_CYCLES, default 10: BUSY duration in cycles for DIV/DIVU.
REQ-003 The block SHALL have exactly one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 A  input  32  operand rs (dividend / multiplicand / MTHI-MTLO source).
REQ-007 B  input  32  operand rt (divisor / multiplier).
REQ-008 MDUOP  input  4  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; all other codes = no-op.
REQ-009 START  input  1  launches MDUOP 0-3 at a rising edge; qualifies MDUOP 4-5 as a write.
REQ-010 BUSY  output  1  operation in progress.
REQ-011 HI  output  32  architectural HI register, read combinationally (MFHI path).
REQ-012 LO  output  32  architectural LO register, read combinationally (MFLO path).

Function
REQ-013 The block SHALL have states IDLE and RUN, a cycle counter, and pending-result registers PHI/PLO.
REQ-014 IDLE, START=1, MDUOP 0-3 at edge k -> the block SHALL compute and latch the result in PHI/PLO, load the counter with N (MULT_CYCLES or DIV_CYCLES), and enter RUN.
REQ-015 BUSY SHALL equal 1 exactly when the state is RUN: from after edge k through edge k+N, i.e. N cycles.
REQ-016 In RUN, each edge SHALL decrement the counter; at the edge where the counter is 1, HI<=PHI, LO<=PLO, state<=IDLE, BUSY falls.
REQ-017 HI/LO SHALL hold their old values throughout RUN; the new values become visible only after edge k+N.
REQ-018 MULT: {HI,LO} = signed 32x32 -> 64-bit product; MULTU: unsigned 64-bit product.
REQ-019 DIV: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
REQ-020 DIVU: LO = unsigned quotient; HI = unsigned remainder.
REQ-021 Divide by zero (B==0, DIV/DIVU): BUSY SHALL run the full DIV_CYCLES, and HI/LO SHALL be left unchanged at commit.
REQ-022 DIV with 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
REQ-023 START=1 with MDUOP 4 in IDLE: HI<=A at that edge; with MDUOP 5: LO<=A; BUSY SHALL stay 0.
REQ-024 Any START while BUSY=1 (MDUOP 0-5) SHALL be ignored: no restart, no HI/LO write, counter unaffected.
REQ-025 At the commit edge (BUSY falling), a simultaneous START SHALL be ignored; a new START is accepted from the next edge with BUSY=0.
REQ-026 START=1 with MDUOP 6-15 SHALL have no effect.
REQ-027 A and B SHALL only be sampled at the START edge; changes during RUN SHALL not affect the result.

Reset
REQ-028 Asserting reset SHALL immediately force HI=0, LO=0, PHI=0, PLO=0, counter=0, state=IDLE, BUSY=0, independent of clk.
REQ-029 Reset during RUN SHALL abort the operation with no commit; after reset is released, the first START SHALL be accepted normally.

Verification
REQ-030 MULT A=0xFFFFFFFE (-2), B=3 -> BUSY=1 for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-031 MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
REQ-032 DIV A=0xFFFFFFF9 (-7), B=2 -> BUSY=1 for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. A following DIVU A=7, B=0 -> HI/LO unchanged after 10 cycles.
REQ-033 MTHI A=0x12345678, then a MULT (1x1) with a START pulse at cycle 2 of BUSY -> HI=0x12345678 during BUSY; after commit HI=0, LO=1; the second START has no effect.
REQ-034 DIVU A=100, B=7 with reset asserted at cycle 4 of BUSY -> BUSY=0, HI=LO=0 immediately, no later commit; a subsequent MTLO A=5 gives LO=5.
REQ-035 START MULT exactly at the commit edge of a prior DIV -> the START is ignored; BUSY stays 0 after the commit edge.

Source files
------------

// File: rtl/mdu.sv
// Multiply/divide unit with architectural HI/LO registers.
// A launched MULT/MULTU/DIV/DIVU computes its result in the launch cycle into
// pending registers PHI/PLO, then holds BUSY for a fixed number of cycles
// before committing to HI/LO. MTHI/MTLO write HI/LO directly when idle.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDUOP,
    input  logic        START,
    output logic        BUSY,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     phi_q, phi_d, plo_q, plo_d;
    logic [31:0]     hi_q, hi_d, lo_q, lo_d;

    logic [63:0]     prod_s, prod_u;
    logic            div_signed;
    logic [31:0]     dvd, dvs, quo, rem;
    logic [31:0]     div_lo, div_hi;

    // Datapath: products and a single magnitude divider shared by DIV/DIVU.
    // Signed division works on magnitudes and fixes signs afterwards, which
    // also yields 0x80000000 / -1 = 0x80000000 rem 0 without overflow.
    always_comb begin
        prod_u     = {32'b0, A} * {32'b0, B};
        prod_s     = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        div_signed = (MDUOP == OP_DIV);
        dvd        = (div_signed && A[31]) ? (32'd0 - A) : A;
        dvs        = (div_signed && B[31]) ? (32'd0 - B) : B;
        quo        = (dvs == 32'd0) ? 32'd0 : dvd / dvs;
        rem        = (dvs == 32'd0) ? 32'd0 : dvd % dvs;
        div_lo     = (div_signed && (A[31] ^ B[31])) ? (32'd0 - quo) : quo;
        div_hi     = (div_signed && A[31]) ? (32'd0 - rem) : rem;
    end

    // Next-state logic: launch/direct writes in IDLE, count down and commit in RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (START) begin
                    case (MDUOP)
                        OP_MULT: begin
                            {phi_d, plo_d} = prod_s;
                            cnt_d   = CW'(MULT_CYCLES);
                            state_d = RUN;
                        end
                        OP_MULTU: begin
                            {phi_d, plo_d} = prod_u;
                            cnt_d   = CW'(MULT_CYCLES);
                            state_d = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            // Divide by zero re-commits the current HI/LO,
                            // which cannot change while RUN is active.
                            if (B == 32'd0) begin
                                phi_d = hi_q;
                                plo_d = lo_q;
                            end else begin
                                phi_d = div_hi;
                                plo_d = div_lo;
                            end
                            cnt_d   = CW'(DIV_CYCLES);
                            state_d = RUN;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    hi_d    = phi_q;
                    lo_d    = plo_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and register update; reset aborts any operation without commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign BUSY = (state_q == RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: scoreboard of expected HI/LO/BUSY-length per
// launched operation, popped when BUSY falls.
module tb_mdu;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] A = '0, B = '0;
    logic [3:0]  MDUOP = '0;
    logic        START = 1'b0;
    logic        BUSY;
    logic [31:0] HI, LO;

    mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .MDUOP(MDUOP),
        .START(START), .BUSY(BUSY), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] mhi = '0, mlo = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model, computed with 64-bit integer arithmetic.
    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = {mhi, mlo};
        case (op)
            4'd0: res = 64'(sa * sb);
            4'd1: res = {32'b0, a} * {32'b0, b};
            4'd2: if (b != 0) begin
                q = sa / sb;
                r = sa % sb;
                res = {r[31:0], q[31:0]};
            end
            4'd3: if (b != 0) res = {a % b, a / b};
            default: ;
        endcase
        return res;
    endfunction

    // Launch a long op; optionally pulse START (pop/pa) at BUSY cycle pulse_cyc.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int pulse_cyc, input logic [3:0] pop, input logic [31:0] pa);
        exp_t e, g;
        int cnt;
        logic [63:0] r;
        r = model(op, a, b);
        e.hi = r[63:32];
        e.lo = r[31:0];
        e.n  = (op < 4'd2) ? MC : DC;
        sb.push_back(e);
        START = 1'b1; MDUOP = op; A = a; B = b;
        @(negedge clk);
        START = 1'b0;
        cnt = 0;
        while (BUSY && cnt < 100) begin
            cnt++;
            A = $urandom; B = $urandom;
            if (HI !== mhi || LO !== mlo) chk("hold_hilo", {HI, LO}, {mhi, mlo});
            if (cnt == pulse_cyc) begin
                START = 1'b1; MDUOP = pop; A = pa; B = 32'd1;
            end
            @(negedge clk);
            START = 1'b0;
        end
        g = sb.pop_front();
        chk("busy_len", 64'(cnt), 64'(g.n));
        chk("hi", 64'(HI), 64'(g.hi));
        chk("lo", 64'(LO), 64'(g.lo));
        mhi = g.hi;
        mlo = g.lo;
        @(negedge clk);
        chk("busy_after", 64'(BUSY), 64'd0);
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] a);
        START = 1'b1; MDUOP = op; A = a;
        @(negedge clk);
        START = 1'b0;
        if (op == 4'd4) mhi = a;
        if (op == 4'd5) mlo = a;
        chk("mt_busy", 64'(BUSY), 64'd0);
        chk("mt_hilo", {HI, LO}, {mhi, mlo});
    endtask

    initial begin
        #12;
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_hilo", {HI, LO}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_op(4'd0, 32'hFFFFFFFE, 32'd3, 0, 4'd0, 32'd0);
        chk("mult_neg", {HI, LO}, 64'hFFFFFFFF_FFFFFFFA);
        run_op(4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 4'd0, 32'd0);
        chk("multu_max", {HI, LO}, 64'hFFFFFFFE_00000001);
        run_op(4'd2, 32'hFFFFFFF9, 32'd2, 0, 4'd0, 32'd0);
        chk("div_neg", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
        run_op(4'd3, 32'd7, 32'd0, 0, 4'd0, 32'd0);
        chk("divu_zero", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
        run_op(4'd2, 32'h80000000, 32'hFFFFFFFF, 0, 4'd0, 32'd0);
        chk("div_ovf", {HI, LO}, 64'h00000000_80000000);
        run_op(4'd2, 32'd5, 32'd0, 0, 4'd0, 32'd0);
        run_op(4'd2, 32'd7, 32'hFFFFFFFE, 0, 4'd0, 32'd0);

        // Random long ops.
        for (int i = 0; i < 8; i++)
            run_op(4'($urandom_range(0, 3)), $urandom, (i == 3) ? 32'd0 : $urandom,
                   0, 4'd0, 32'd0);

        // MTHI then MULT 1x1 with an ignored MTHI pulse in BUSY cycle 2.
        mt(4'd4, 32'h12345678);
        run_op(4'd0, 32'd1, 32'd1, 2, 4'd4, 32'hDEADBEEF);
        chk("mthi_mult", {HI, LO}, 64'h00000000_00000001);

        // Ignored MULT launch in RUN, and no-op codes in IDLE.
        run_op(4'd1, 32'd9, 32'd9, 3, 4'd1, 32'd3);
        for (int op = 6; op < 16; op++) mt(4'(op), 32'hA5A5A5A5);
        mt(4'd5, 32'h0BADF00D);

        // MULT launched exactly on the DIV commit edge must be dropped.
        run_op(4'd2, 32'd100, 32'd3, DC, 4'd0, 32'd2);
        @(negedge clk);
        chk("commit_start_busy", 64'(BUSY), 64'd0);

        // Reset during RUN aborts with no commit.
        START = 1'b1; MDUOP = 4'd3; A = 32'd100; B = 32'd7;
        @(negedge clk);
        START = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", 64'(BUSY), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_run_busy", 64'(BUSY), 64'd0);
        chk("rst_run_hilo", {HI, LO}, 64'd0);
        mhi = '0; mlo = '0;
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("no_commit", {HI, LO}, 64'd0);
        chk("no_commit_busy", 64'(BUSY), 64'd0);
        mt(4'd5, 32'd5);
        chk("mtlo_after_rst", 64'(LO), 64'd5);
        run_op(4'd3, 32'd100, 32'd7, 0, 4'd0, 32'd0);
        chk("divu_after_rst", {HI, LO}, {32'd2, 32'd14});

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
